// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state codes and default width.
package seq_div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int N_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor,
// keep the difference when it is non-negative, otherwise restore.
module div_step #(
    parameter int N = 4
) (
    input  logic [N-1:0] rem_cur,
    input  logic [N-1:0] quo_cur,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_nxt,
    output logic [N-1:0] quo_nxt
);

    logic [N:0] shifted_s;
    logic [N:0] trial_s;

    // Trial subtraction in N+1 bits; bit N is the sign of the difference
    always_comb begin
        shifted_s = {rem_cur, quo_cur[N-1]};
        trial_s   = shifted_s - {1'b0, divisor};
        if (trial_s[N] == 1'b0) begin
            rem_nxt = trial_s[N-1:0];
            quo_nxt = {quo_cur[N-2:0], 1'b1};
        end else begin
            rem_nxt = shifted_s[N-1:0];
            quo_nxt = {quo_cur[N-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);

    state_t         state_r,       state_s;
    logic [CW-1:0]  count_r,       count_s;
    logic [N-1:0]   rem_r,         rem_s;
    logic [N-1:0]   quo_r,         quo_s;
    logic [N-1:0]   dvs_r,         dvs_s;
    logic           dbz_r,         dbz_s;
    logic           in_ready_r,    in_ready_s;
    logic           out_valid_r,   out_valid_s;
    logic [N-1:0]   quotient_r,    quotient_s;
    logic [N-1:0]   remainder_r,   remainder_s;
    logic           div_by_zero_r, div_by_zero_s;
    logic [N-1:0]   step_rem_s;
    logic [N-1:0]   step_quo_s;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic           neg_quo_r,     neg_quo_s;
    logic           neg_rem_r,     neg_rem_s;

    function automatic logic [N-1:0] neg_if(input logic neg, input logic [N-1:0] v);
        if (neg) begin
            neg_if = ~v + {{(N-1){1'b0}}, 1'b1};
        end else begin
            neg_if = v;
        end
    endfunction
`endif

    div_step #(.N(N)) u_step (
        .rem_cur (rem_r),
        .quo_cur (quo_r),
        .divisor (dvs_r),
        .rem_nxt (step_rem_s),
        .quo_nxt (step_quo_s)
    );

    // Next-state and datapath decode; every register holds unless its state acts on it
    always_comb begin
        state_s       = state_r;
        count_s       = count_r;
        rem_s         = rem_r;
        quo_s         = quo_r;
        dvs_s         = dvs_r;
        dbz_s         = dbz_r;
        in_ready_s    = in_ready_r;
        out_valid_s   = out_valid_r;
        quotient_s    = quotient_r;
        remainder_s   = remainder_r;
        div_by_zero_s = div_by_zero_r;
`ifdef SEQ_DIVIDER_SIGNED_EN
        neg_quo_s     = neg_quo_r;
        neg_rem_s     = neg_rem_r;
`endif
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_s    = CALC;
                    rem_s      = {N{1'b0}};
                    count_s    = {CW{1'b0}};
                    dbz_s      = (divisor == {N{1'b0}});
                    in_ready_s = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    // Divide magnitudes; signs are reapplied when the result is registered
                    quo_s      = neg_if(dividend[N-1], dividend);
                    dvs_s      = neg_if(divisor[N-1], divisor);
                    neg_quo_s  = dividend[N-1] ^ divisor[N-1];
                    neg_rem_s  = dividend[N-1];
`else
                    quo_s      = dividend;
                    dvs_s      = divisor;
`endif
                end else begin
                    in_ready_s = 1'b1;
                end
            end
            CALC: begin
                rem_s   = step_rem_s;
                quo_s   = step_quo_s;
                count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
                if (count_r == CW'(N - 1)) begin
                    state_s       = DONE;
                    out_valid_s   = 1'b1;
                    div_by_zero_s = dbz_r;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    // A zero divisor must report -1 whatever the dividend sign
                    quotient_s    = dbz_r ? {N{1'b1}} : neg_if(neg_quo_r, step_quo_s);
                    remainder_s   = neg_if(neg_rem_r, step_rem_s);
`else
                    quotient_s    = step_quo_s;
                    remainder_s   = step_rem_s;
`endif
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s     = IDLE;
                    out_valid_s = 1'b0;
                    in_ready_s  = 1'b1;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s     = IDLE;
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            count_r       <= {CW{1'b0}};
            rem_r         <= {N{1'b0}};
            quo_r         <= {N{1'b0}};
            dvs_r         <= {N{1'b0}};
            dbz_r         <= 1'b0;
            in_ready_r    <= 1'b1;
            out_valid_r   <= 1'b0;
            quotient_r    <= {N{1'b0}};
            remainder_r   <= {N{1'b0}};
            div_by_zero_r <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo_r     <= 1'b0;
            neg_rem_r     <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            count_r       <= count_s;
            rem_r         <= rem_s;
            quo_r         <= quo_s;
            dvs_r         <= dvs_s;
            dbz_r         <= dbz_s;
            in_ready_r    <= in_ready_s;
            out_valid_r   <= out_valid_s;
            quotient_r    <= quotient_s;
            remainder_r   <= remainder_s;
            div_by_zero_r <= div_by_zero_s;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo_r     <= neg_quo_s;
            neg_rem_r     <= neg_rem_s;
`endif
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (N=4): stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_seq_divider;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb_q[$];
    int   npass  = 0;
    int   ntotal = 0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) begin
            npass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted result must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                ntotal++;
                $display("FAIL unexpected_result: got q=%0d r=%0d with empty scoreboard", quotient, remainder);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            end
        end
    end

    // Count edges after an accept until out_valid, checking in_ready stays low
    task automatic wait_result(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic ed, input int hold);
        int guard;
        int lat;
        bit busy_ok;
        bit stable;
        exp_t e;
        guard = 0;
        out_ready = (hold == 0);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("accept_timeout", 32'(guard < 50), 32'd1);
        e.q = eq; e.r = er; e.dbz = ed;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        wait_result(lat, busy_ok);
        chk("latency", 32'(lat), 32'(N));
        chk("in_ready_busy", 32'(busy_ok), 32'd1);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (out_valid !== 1'b1 || quotient !== eq || remainder !== er) stable = 1'b0;
            @(posedge clk); #1;
        end
        if (hold > 0) chk("hold_stable", 32'(stable), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_handshake", 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        int n;
        int lat;
        bit busy_ok;
        exp_t e;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        dividend  = 4'd0;
        divisor   = 4'd0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        chk("reset_state", 32'({in_ready, out_valid, quotient, remainder, div_by_zero}), 32'b1_0_0000_0000_0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef SEQ_DIVIDER_SIGNED_EN
        issue(4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 0);   // -7 / 2
        issue(4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 0);   // -8 / -1
        issue(4'b0110, 4'b1100, 4'b1111, 4'b0010, 1'b0, 0);   // 6 / -4
        issue(4'b0111, 4'b0000, 4'b1111, 4'b0111, 1'b1, 0);   // 7 / 0
        issue(4'b1010, 4'b0000, 4'b1111, 4'b1010, 1'b1, 3);   // -6 / 0
        issue(4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 0);   // 7 / 2
`else
        issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 0);

        // Back-to-back with in_valid held across the busy period
        dividend = 4'd15; divisor = 4'd1; in_valid = 1'b1; out_ready = 1'b1;
        e.q = 4'd15; e.r = 4'd0; e.dbz = 1'b0; sb_q.push_back(e);
        e.q = 4'd0;  e.r = 4'd0; e.dbz = 1'b0; sb_q.push_back(e);
        @(posedge clk); #1;
        dividend = 4'd0; divisor = 4'd7;
        n = 0;
        busy_ok = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n < N + 1 && in_ready !== 1'b0) busy_ok = 1'b0;
        end
        chk("reaccept_gap", 32'(n), 32'(N + 1));
        chk("in_ready_b2b", 32'(busy_ok), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(lat, busy_ok);
        chk("latency_b2b", 32'(lat), 32'(N));
        @(posedge clk); #1;

        issue(4'd7, 4'd0, 4'd15, 4'd7, 1'b1, 0);
        issue(4'd9, 4'd4, 4'd2, 4'd1, 1'b0, 5);

        // Reset two cycles into a calculation discards it
        dividend = 4'd11; divisor = 4'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_calc", 32'({in_ready, out_valid, quotient, remainder, div_by_zero}), 32'b1_0_0000_0000_0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        issue(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 0);
`endif

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative unsigned restoring divider; the inverse operation of the team's combinational Wallace-tree multiplier.
- Produces quotient and remainder of two N-bit operands, one quotient bit per clock.
- Valid/ready handshake on input and output, so it drops into the same datapath that consumes multiplier products.
- Small area, fixed deterministic latency.

Parameters:
- N, 4, operand/quotient/remainder width in bits (N >= 2).
- CW, $clog2(N+1), iteration-counter width (derived; not to be overridden).

Ports:
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- dividend  in  N  numerator.
- divisor  in  N  denominator.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- quotient  out  N  dividend / divisor.
- remainder  out  N  dividend mod divisor.
- div_by_zero  out  1  flag qualified by out_valid: divisor was 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- States: IDLE, CALC, DONE. Encoding is 2-bit binary.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0: capture divisor; load Q=dividend, R=0, count=0; latch dbz=(divisor==0); go to CALC.
- CALC:
  - in_ready=0.
  - At each edge: {R,Q} shifts left by 1; trial T=R'-divisor uses N+1 bits.
  - If T is non-negative, R=T and Q[0]=1; otherwise R is restored and Q[0]=0.
  - count increments each edge.
  - At the edge where count reaches N-1 (edge EN, the Nth iteration), go to DONE.
- DONE:
  - out_valid=1; quotient=Q, remainder=R, div_by_zero=dbz.
  - All three outputs stay stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE, out_valid=0.
  - in_ready stays 0 during the handshake cycle, so there is no same-cycle re-accept.
- Latency: out_valid rises exactly N clock edges after the accept edge. Throughput is one operation per N+2 cycles with out_ready held high.
- Divide by zero:
  - Runs the same N iterations (fixed latency).
  - The natural restoring result is quotient=all ones, remainder=dividend; this is the required result.
  - div_by_zero=1.
- in_valid while busy (CALC or DONE): ignored. Operands are not captured, and upstream must hold them.
- Operands may change after the accept edge without affecting the result.
- rst_n asserted mid-CALC or mid-DONE: immediate return to the reset values; the result is discarded.
- out_ready asserted outside DONE: no effect.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- When defined:
  - Operands are two's complement.
  - Magnitudes are divided as above; quotient is negated when the operand signs differ (truncation toward zero); remainder takes the dividend's sign.
  - Overflow case (most negative / -1): returns the most negative value, remainder 0.
  - Divide by zero: quotient=-1 (all ones), remainder=dividend, flag=1.
  - Sign fix-up is registered on entry to DONE; latency is unchanged at N.
- When undefined: purely unsigned; no sign logic is synthesized.

Decomposition:
- Package seq_div_pkg holds:
  - state localparams ST_IDLE=0, ST_CALC=1, ST_DONE=2;
  - the default width N_DEF=4.
- One combinational sub-module, div_step:
  - inputs R, Q, divisor;
  - outputs next R and next Q for a single restoring iteration;
  - instantiated once, used by the CALC datapath.

Test Plan:
- N=4, 13/3, out_ready=1: out_valid exactly 4 edges after accept; quotient=4, remainder=1, div_by_zero=0.
- 15/1 then 0/7 back-to-back (in_valid held): quotient=15, remainder=0, then quotient=0, remainder=0; second accept only after the first handshake; in_ready=0 throughout CALC/DONE.
- 7/0: quotient=15, remainder=7, div_by_zero=1, latency still 4.
- 9/4 with out_ready=0 for 5 cycles after out_valid: quotient=2, remainder=1 held stable all 5 cycles; IDLE one edge after out_ready=1.
- Assert rst_n=0 two cycles into CALC of 11/2: all outputs at reset values immediately. A new 11/2 after release yields quotient=5, remainder=1.
- With SEQ_DIVIDER_SIGNED_EN:
  - -7/2 gives quotient=1101, remainder=1111.
  - -8/-1 gives quotient=1000, remainder=0000.
  - 6/-4 gives quotient=1111, remainder=0010.
